// File: rtl/addr_gen_l1.sv
// addr_gen_l1: layer-1 loop tuple -> ifmap read address (2 cycles) and ofmap write address/strobe (WR_DLY cycles).
// en=0 freezes every stage and blanks the strobes; nothing is dropped or replayed when en returns.
module addr_gen_l1 #(
   parameter int IN_W   = 32,
   parameter int OUT_W  = 30,
   parameter int K      = 3,
   parameter int ADDR_W = 10,
   parameter int WR_DLY = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [4:0]        x,
   input  logic [4:0]        y,
   input  logic [1:0]        k,
   input  logic [1:0]        j,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              rd_valid,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              wr_en,
   output logic              done,
   output logic              err
);

   localparam logic [4:0] PIX_MAX = 5'(OUT_W - 1);
   localparam logic [1:0] TAP_MAX = 2'(K - 1);
   localparam int         DEPTH   = WR_DLY - 2;

   typedef struct packed {
      logic       vld;
      logic       last;
      logic [9:0] pix;
      logic       fin;
   } wr_ent_t;

   wr_ent_t     s1_ent_q, s1_ent_d;
   logic [5:0]  s1_row_q, s1_row_d;
   logic [5:0]  s1_col_q, s1_col_d;
   wr_ent_t     s2_ent_q;
   logic [ADDR_W-1:0] s2_addr_q;
   wr_ent_t     dly_q [DEPTH];
   wr_ent_t     tail;
   logic        bad_d;
   logic [11:0] rd_full;
   logic [11:0] wr_full;

   logic [ADDR_W-1:0] rd_addr_q, wr_addr_q;
   logic              rd_valid_q, wr_en_q, done_q, err_q;

   always_comb begin
      s1_ent_d      = '0;
      s1_row_d      = {1'b0, x} + {4'b0, k};
      s1_col_d      = {1'b0, y} + {4'b0, j};
      s1_ent_d.vld  = 1'b1;
      s1_ent_d.last = (k == TAP_MAX) && (j == TAP_MAX);
      s1_ent_d.pix  = {x, y};
      s1_ent_d.fin  = s1_ent_d.last && (x == PIX_MAX) && (y == PIX_MAX);
      bad_d   = en && ((x > PIX_MAX) || (y > PIX_MAX) || (k > TAP_MAX) || (j > TAP_MAX));
      rd_full = 12'(s1_row_q) * 12'(IN_W) + 12'(s1_col_q);
      tail    = dly_q[DEPTH-1];
      wr_full = 12'(tail.pix[9:5]) * 12'(OUT_W) + 12'(tail.pix[4:0]);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_ent_q   <= '0;
         s1_row_q   <= '0;
         s1_col_q   <= '0;
         s2_ent_q   <= '0;
         s2_addr_q  <= '0;
         for (int i = 0; i < DEPTH; i++) dly_q[i] <= '0;
         rd_addr_q  <= '0;
         rd_valid_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_en_q    <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         err_q      <= err_q | bad_d;
         // Strobes fire only on advancing edges, so a held entry is never shown twice.
         rd_valid_q <= en & s2_ent_q.vld;
         wr_en_q    <= en & tail.vld & tail.last;
         done_q     <= en & tail.vld & tail.fin;
         if (en) begin
            s1_ent_q  <= s1_ent_d;
            s1_row_q  <= s1_row_d;
            s1_col_q  <= s1_col_d;
            s2_ent_q  <= s1_ent_q;
            s2_addr_q <= rd_full[ADDR_W-1:0];
            dly_q[0]  <= s2_ent_q;
            for (int i = 1; i < DEPTH; i++) dly_q[i] <= dly_q[i-1];
            rd_addr_q <= s2_addr_q;
            wr_addr_q <= wr_full[ADDR_W-1:0];
         end
      end
   end

   assign rd_addr  = rd_addr_q;
   assign rd_valid = rd_valid_q;
   assign wr_addr  = wr_addr_q;
   assign wr_en    = wr_en_q;
   assign done     = done_q;
   assign err      = err_q;

endmodule

// File: tb/tb_addr_gen_l1.sv
// Directed bench for addr_gen_l1: tuple history model plus hand-computed spot values.
module tb_addr_gen_l1;

   localparam int WR_DLY = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en  = 1'b0;
   logic [4:0] x = '0, y = '0;
   logic [1:0] k = '0, j = '0;
   logic [9:0] rd_addr, wr_addr;
   logic       rd_valid, wr_en, done, err;

   int nvec = 0;
   int nerr = 0;

   // Tuples accepted since reset: read address, write address, last, fin, out-of-range.
   int qa[$], qw[$], ql[$], qf[$], qb[$];
   int ne    = 0;
   int err_m = 0;

   addr_gen_l1 #(.IN_W(32), .OUT_W(30), .K(3), .ADDR_W(10), .WR_DLY(WR_DLY)) dut (
      .clk(clk), .rst(rst), .en(en), .x(x), .y(y), .k(k), .j(j),
      .rd_addr(rd_addr), .rd_valid(rd_valid), .wr_addr(wr_addr), .wr_en(wr_en),
      .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step(input logic r, input logic e, input int xi, input int yi, input int ki, input int ji);
      int ri, wi, lst;
      logic exp_rv, exp_we, exp_dn;
      rst = r; en = e;
      x = 5'(xi); y = 5'(yi); k = 2'(ki); j = 2'(ji);
      @(posedge clk);
      #1;
      if (!r) begin
         qa.delete(); qw.delete(); ql.delete(); qf.delete(); qb.delete();
         ne = 0; err_m = 0;
      end else if (e) begin
         lst = (ki == 2 && ji == 2) ? 1 : 0;
         qa.push_back(((xi + ki) * 32 + yi + ji) % 1024);
         qw.push_back(xi * 30 + yi);
         ql.push_back(lst);
         qf.push_back((lst == 1 && xi == 29 && yi == 29) ? 1 : 0);
         qb.push_back((xi > 29 || yi > 29 || ki > 2 || ji > 2) ? 1 : 0);
         if (qb[ne] != 0) err_m = 1;
         ne++;
      end
      ri = ne - 3;
      wi = ne - 1 - WR_DLY;
      exp_rv = r && e && ri >= 0;
      exp_we = r && e && wi >= 0 && ql[wi] != 0;
      exp_dn = exp_we && qf[wi] != 0;
      chk("rd_valid", rd_valid, exp_rv);
      chk("wr_en", wr_en, exp_we);
      chk("done", done, exp_dn);
      chk("err", err, err_m);
      if (exp_rv && qb[ri] == 0) chk("rd_addr", rd_addr, qa[ri]);
      if (exp_we) chk("wr_addr", wr_addr, qw[wi]);
   endtask

   int win[9] = '{100, 101, 102, 132, 133, 134, 164, 165, 166};

   initial begin
      // Reset state
      step(0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);
      chk("rst_rd_addr", rd_addr, 0);
      chk("rst_wr_addr", wr_addr, 0);

      // Single tuples, then a full window at (3,4)
      step(1, 1, 0, 0, 0, 0);
      step(1, 1, 5, 7, 2, 1);
      for (int t = 0; t < 9; t++) begin
         step(1, 1, 3, 4, t / 3, t % 3);
         if (t == 0) chk("first_rd", rd_addr, 0);
         if (t == 1) chk("tap21_rd", rd_addr, 232);
         if (t >= 2) chk("win_rd", rd_addr, win[t-2]);
      end
      for (int f = 0; f < 5; f++) begin
         step(1, 1, 10, 10, 0, 0);
         if (f == 0) chk("win_rd7", rd_addr, win[7]);
         if (f == 1) chk("win_rd8", rd_addr, win[8]);
         if (f == 3) begin
            chk("win_we", wr_en, 1);
            chk("win_wa", wr_addr, 94);
         end
      end

      // Final tuple followed immediately by the next layer's first tuples
      step(1, 1, 29, 29, 2, 2);
      for (int f = 0; f < 5; f++) begin
         step(1, 1, 0, 0, 0, f % 2);
         if (f == 1) chk("final_rd", rd_addr, 1023);
         if (f == 3) begin
            chk("final_wa", wr_addr, 899);
            chk("final_done", done, 1);
         end
         if (f == 4) chk("done_once", done, 0);
      end

      // Final tuple reaches the tail while en is low
      step(1, 1, 29, 29, 2, 2);
      for (int f = 0; f < 3; f++) step(1, 1, 1, 1, 0, 0);
      step(1, 0, 1, 1, 0, 0);
      step(1, 0, 1, 1, 0, 0);
      chk("held_done", done, 0);
      step(1, 1, 1, 1, 0, 1);
      chk("late_done", done, 1);
      step(1, 1, 1, 1, 0, 2);
      chk("late_done_once", done, 0);

      // Five tuples with a three-cycle stall in the middle
      step(1, 1, 1, 2, 0, 0);
      step(1, 1, 1, 2, 0, 1);
      for (int g = 0; g < 3; g++) step(1, 0, 7, 7, 2, 2);
      step(1, 1, 1, 2, 0, 2);
      step(1, 1, 1, 2, 1, 0);
      step(1, 1, 1, 2, 1, 1);
      step(1, 1, 4, 4, 0, 0);
      step(1, 1, 4, 4, 0, 0);

      // Reset mid-stream discards a pending write
      step(1, 1, 2, 2, 2, 2);
      step(1, 1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);
      chk("mid_rst_rv", rd_valid, 0);
      chk("mid_rst_ra", rd_addr, 0);
      chk("mid_rst_wa", wr_addr, 0);
      for (int f = 0; f < 6; f++) step(1, 1, 6, 6, 1, 1);

      // Sticky range error
      step(1, 1, 30, 0, 0, 0);
      chk("err_set", err, 1);
      for (int f = 0; f < 4; f++) step(1, 1, 2, 3, 0, 0);
      chk("err_sticky", err, 1);
      step(0, 1, 0, 0, 0, 0);
      chk("err_clr", err, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
